mux16_rr_sched: RTL and testbench
=================================

// Module: mux16_rr_sched
// PURPOSE
//   Round-robin scheduler that shares one 16:1 gate-level select mux among 16 requesters.
//   It drives the mux's 4-bit select and a one-hot grant vector.
//   Every grant is bounded: it ends on requester 'done', on request withdrawal, or after HOLD_MAX cycles.
//   Between any two grants it inserts one dead cycle, so the combinational mux output settles before reuse.
// PARAMETERS
//   HOLD_MAX  8  max consecutive cycles one requester may hold the mux (legal range 1..255)
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   en         in   1   scheduler enable; low = no new grants, current grant is released
//   req        in   16  request per mux input; req[i] means input i wants the mux
//   done       in   1   current owner finished; sampled only in GRANT
//   sel        out  4   select for the 16:1 mux (registered)
//   sel_valid  out  1   high while sel addresses a granted input (registered)
//   grant      out  16  one-hot grant, equals (1<<sel) when sel_valid, else 0 (registered)
//   preempt    out  1   1-cycle pulse: grant was ended by HOLD_MAX expiry
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     state=IDLE, sel=0, sel_valid=0, grant=0, preempt=0, hold_cnt=0, last=15.
//     Takes effect immediately, including mid-grant.
//   Arbitration (combinational):
//     winner = first i with req[i]=1, scanning last+1, last+2, ... mod 16 (wraps 15->0).
//     With last=15 after reset, the scan starts at input 0.
//   States:
//     IDLE:
//       - sel_valid=0, grant=0.
//       - If en && |req: next state GRANT; register sel=winner, grant=1<<winner, sel_valid=1,
//         last=winner, hold_cnt=1.
//       - Latency: request seen at edge k -> sel_valid high after edge k.
//     GRANT:
//       - sel and grant are held stable.
//       - Release conditions, evaluated each cycle: done | ~req[sel] | ~en | (hold_cnt==HOLD_MAX).
//       - Any condition true -> RELEASE at next edge. Otherwise hold_cnt++.
//       - sel_valid is therefore high at most HOLD_MAX cycles.
//       - preempt=1 in the RELEASE cycle only if expiry was the sole cause
//         (no done, req still high, en high).
//     RELEASE (exactly 1 cycle):
//       - sel_valid=0, grant=0; sel keeps its previous value (no select glitch).
//       - Next state GRANT with a fresh arbitration if en && |req, else IDLE.
//       - A single persistent requester therefore gets HOLD_MAX on / 1 off, repeated.
//   Boundary rules:
//     - done outside GRANT is ignored.
//     - done together with expiry -> preempt=0.
//     - req changes in IDLE/RELEASE only affect the winner chosen at that edge.
//     - Requests to a non-owner during GRANT are never granted early.
//     - en low in IDLE/RELEASE blocks granting; en low in GRANT -> RELEASE -> IDLE.
//     - hold_cnt width is 8 bits; it never exceeds HOLD_MAX.
//   Invariants:
//     - grant is one-hot or zero, and grant==(sel_valid ? 1<<sel : 0).
//     - No two consecutive cycles have sel_valid high with different sel.
// TESTING
//   1 Reset: assert rst_n=0 mid-grant (sel=5).
//     -> sel=0, sel_valid=0, grant=0 without waiting for a clock edge.
//     Then release reset, apply req=16'h0001 -> sel=0 granted one edge later.
//   2 Round robin: req=16'h8001 held, done pulsed in every grant cycle.
//     -> sel sequence 0,15,0,15, with one sel_valid=0 cycle between grants.
//   3 Expiry: HOLD_MAX=8, req=16'h0004 held, done=0.
//     -> sel=2, sel_valid=1 for exactly 8 cycles; then preempt=1 and sel_valid=0 for 1 cycle;
//        then sel=2 regranted.
//   4 Wrap: grant input 14 and complete it with done, then req=16'h4003.
//     -> next sel=0, then 1, then 14.
//   5 Enable: en dropped during grant of sel=7 with req=16'hFFFF.
//     -> 1 RELEASE cycle, then IDLE, no grant while en=0.
//     Raise en -> next grant sel=8.
//   6 Collision: done asserted in the cycle hold_cnt==HOLD_MAX.
//     -> release with preempt=0.
//     Separately, req[sel] dropped -> release with preempt=0.

Source files
------------

// File: rtl/mux16_rr_sched_if.sv
// Bundle between the requesters and the 16:1 mux scheduler: request side
// drives en/req/done, the scheduler returns the registered select and grant.
interface mux16_rr_sched_if;
  logic        en;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic        sel_valid;
  logic [15:0] grant;
  logic        preempt;

  modport master (
    output en, req, done,
    input  sel, sel_valid, grant, preempt
  );

  modport slave (
    input  en, req, done,
    output sel, sel_valid, grant, preempt
  );
endinterface

// File: rtl/mux16_rr_sched.sv
// Round-robin owner of a shared 16:1 select mux; grant registered one edge after request.
// No backpressure: grants end on done, request drop, disable or HOLD_MAX, then one dead cycle.
module mux16_rr_sched #(
  parameter int HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mux16_rr_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  last_q, last_d;
  logic        sel_valid_q, sel_valid_d;
  logic [15:0] grant_q, grant_d;
  logic        preempt_q, preempt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;

  logic [3:0]  winner;
  logic [3:0]  idx;
  logic        any_req;
  logic        owner_req;
  logic        expired;
  logic        release_now;

  // Scan downward so the lowest offset after last_q wins; offset 16 wraps to last_q itself.
  always_comb begin
    winner = last_q;
    idx    = '0;
    for (int i = 16; i >= 1; i--) begin
      idx = last_q + 4'(i);
      if (bus.req[idx]) begin
        winner = idx;
      end
    end
  end

  assign any_req     = |bus.req;
  assign owner_req   = bus.req[sel_q];
  assign expired     = (hold_cnt_q == 8'(HOLD_MAX));
  assign release_now = bus.done | ~owner_req | ~bus.en | expired;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    sel_valid_d = sel_valid_q;
    grant_d     = grant_q;
    hold_cnt_d  = hold_cnt_q;
    preempt_d   = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        state_d     = IDLE;
        sel_valid_d = 1'b0;
        grant_d     = '0;
        if (bus.en && any_req) begin
          state_d     = GRANT;
          sel_d       = winner;
          grant_d     = 16'(1) << winner;
          sel_valid_d = 1'b1;
          last_d      = winner;
          hold_cnt_d  = 8'd1;
        end
      end
      GRANT: begin
        if (release_now) begin
          // sel is left untouched so the mux select does not move during the dead cycle.
          state_d     = RELEASE;
          sel_valid_d = 1'b0;
          grant_d     = '0;
          hold_cnt_d  = '0;
          preempt_d   = expired & ~bus.done & owner_req & bus.en;
        end else begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        sel_valid_d = 1'b0;
        grant_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 4'd0;
      last_q      <= 4'd15;
      sel_valid_q <= 1'b0;
      grant_q     <= '0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      sel_valid_q <= sel_valid_d;
      grant_q     <= grant_d;
      preempt_q   <= preempt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.grant     = grant_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched: stimulus queues expected grants
// (select, length in cycles, preempt at end); a negedge monitor pops and checks them.
module tb_mux16_rr_sched;
  logic clk;
  logic rst_n;

  mux16_rr_sched_if bus_if ();

  mux16_rr_sched #(.HOLD_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic [3:0] sel;
    int         len;
    logic       pre;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic       cur_act;
  int         cur_len;
  logic       prev_vld;
  logic [3:0] prev_sel;
  logic       mon_on;
  int         n_chk;
  int         n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic push(input logic [3:0] s, input int l, input logic p);
    exp_t e;
    e.sel = s;
    e.len = l;
    e.pre = p;
    exp_q.push_back(e);
  endtask

  // Advance n rising edges, then step just past the edge to drive or sample.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    logic       falling;
    logic       exp_pre;
    logic [15:0] exp_grant;
    if (mon_on) begin
      exp_grant = bus_if.sel_valid ? (16'(1) << bus_if.sel) : 16'h0;
      check("grant_vs_sel", 32'(bus_if.grant), 32'(exp_grant));
      if (bus_if.sel_valid && prev_vld)
        check("sel_stable_in_grant", 32'(bus_if.sel), 32'(prev_sel));
      falling = !bus_if.sel_valid && prev_vld;
      exp_pre = 1'b0;
      if (bus_if.sel_valid && !prev_vld) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_grant: got sel=%0d expected no grant at %0t", bus_if.sel, $time);
          cur_act = 1'b0;
        end else begin
          cur     = exp_q.pop_front();
          cur_act = 1'b1;
          cur_len = 1;
          check("grant_sel", 32'(bus_if.sel), 32'(cur.sel));
        end
      end else if (bus_if.sel_valid) begin
        cur_len++;
      end
      if (falling && cur_act) begin
        check("grant_len", 32'(cur_len), 32'(cur.len));
        check("sel_held_in_release", 32'(bus_if.sel), 32'(prev_sel));
        exp_pre = cur.pre;
        cur_act = 1'b0;
      end
      check("preempt", 32'(bus_if.preempt), 32'(exp_pre));
    end
    prev_vld = bus_if.sel_valid;
    prev_sel = bus_if.sel;
  end

  initial begin
    int wait_cnt;
    n_chk      = 0;
    n_err      = 0;
    mon_on     = 1'b0;
    cur_act    = 1'b0;
    cur_len    = 0;
    prev_vld   = 1'b0;
    prev_sel   = 4'd0;
    bus_if.en  = 1'b0;
    bus_if.req = 16'h0;
    bus_if.done = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #2;
    check("reset_sel", 32'(bus_if.sel), 32'd0);
    check("reset_sel_valid", 32'(bus_if.sel_valid), 32'd0);
    check("reset_grant", 32'(bus_if.grant), 32'd0);
    check("reset_preempt", 32'(bus_if.preempt), 32'd0);
    rst_n = 1'b1;

    // Test 1: async reset in the middle of a grant to input 5.
    step(1);
    bus_if.en  = 1'b1;
    bus_if.req = 16'h0020;
    step(1);
    check("t1_grant5_valid", 32'(bus_if.sel_valid), 32'd1);
    check("t1_grant5_sel", 32'(bus_if.sel), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_sel", 32'(bus_if.sel), 32'd0);
    check("t1_async_valid", 32'(bus_if.sel_valid), 32'd0);
    check("t1_async_grant", 32'(bus_if.grant), 32'd0);
    #1 rst_n = 1'b1;
    bus_if.req = 16'h0001;
    step(1);
    check("t1_regrant_valid", 32'(bus_if.sel_valid), 32'd1);
    check("t1_regrant_sel", 32'(bus_if.sel), 32'd0);
    check("t1_regrant_grant", 32'(bus_if.grant), 32'h0001);
    bus_if.req = 16'h0;
    step(3);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step(1);
    mon_on = 1'b1;

    // Test 2: two requesters, done held so every grant lasts one cycle.
    push(4'd0, 1, 1'b0);
    push(4'd15, 1, 1'b0);
    push(4'd0, 1, 1'b0);
    push(4'd15, 1, 1'b0);
    bus_if.req  = 16'h8001;
    bus_if.done = 1'b1;
    step(7);
    bus_if.req  = 16'h0;
    bus_if.done = 1'b0;
    step(4);

    // Test 3: single requester runs into HOLD_MAX, gets regranted after one dead cycle.
    push(4'd2, 8, 1'b1);
    push(4'd2, 3, 1'b0);
    bus_if.req = 16'h0004;
    step(12);
    bus_if.req = 16'h0;
    step(4);

    // Test 4: after owning 14, the scan wraps through 15 to 0, 1, then back to 14.
    push(4'd14, 1, 1'b0);
    push(4'd0, 1, 1'b0);
    push(4'd1, 1, 1'b0);
    push(4'd14, 1, 1'b0);
    bus_if.req  = 16'h4000;
    bus_if.done = 1'b1;
    step(1);
    bus_if.req  = 16'h4003;
    step(6);
    bus_if.req  = 16'h0;
    bus_if.done = 1'b0;
    step(4);

    // Test 5: en drops while 7 owns the mux; other requesters must not sneak in.
    push(4'd7, 2, 1'b0);
    push(4'd8, 1, 1'b0);
    bus_if.req = 16'h0080;
    step(1);
    bus_if.req = 16'hFFFF;
    step(1);
    bus_if.en = 1'b0;
    step(6);
    bus_if.en   = 1'b1;
    bus_if.done = 1'b1;
    step(1);
    bus_if.req  = 16'h0;
    bus_if.done = 1'b0;
    step(4);

    // Test 6a: done in the same cycle as expiry gives no preempt.
    push(4'd9, 8, 1'b0);
    bus_if.req = 16'h0200;
    step(8);
    bus_if.done = 1'b1;
    step(1);
    bus_if.req  = 16'h0;
    bus_if.done = 1'b0;
    step(4);

    // Test 6b: owner withdraws its request.
    push(4'd10, 3, 1'b0);
    bus_if.req = 16'h0400;
    step(3);
    bus_if.req = 16'h0;
    step(4);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      step(1);
      wait_cnt++;
    end
    check("all_grants_seen", 32'(exp_q.size()), 32'd0);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
